// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared state encodings and constants for the boot-time instruction loader
package instr_loader_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE   = 3'd0,
    LDR_HDR_HI = 3'd1,
    LDR_HDR_LO = 3'd2,
    LDR_DATA   = 3'd3,
    LDR_WRITE  = 3'd4,
    LDR_DONE   = 3'd5,
    LDR_ERROR  = 3'd6,
    LDR_CSUM   = 3'd7
  } ldr_state_t;

  // Header is a 16-bit big-endian word count.
  localparam int HDR_LEN = 2;

  function automatic logic [31:0] word_byte_addr(input logic [15:0] idx);
    return {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/instr_loader_word_assembler.sv
// rtl/instr_loader_word_assembler.sv - big-endian byte-to-word shift register with byte counter and full flag
module instr_loader_word_assembler
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last,
  output logic        full
);

  logic [1:0] count_q;

  // The word register is left intact on clear so the memory data bus stays quiet between words.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word    <= 32'd0;
      count_q <= 2'd0;
      full    <= 1'b0;
    end else if (clear) begin
      count_q <= 2'd0;
      full    <= 1'b0;
    end else if (shift) begin
      word    <= {word[23:0], byte_in};
      count_q <= count_q + 2'd1;
      full    <= (count_q == 2'd3);
    end
  end

  assign last = (count_q == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - loads a length-prefixed byte image into instruction memory, holding the CPU in reset
// Optional trailing XOR checksum byte is enabled with LOADER_CHECKSUM_EN.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned INSTR_MEM_SIZE = 1024
)
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  ldr_state_t  state_q, state_d;
  logic [15:0] word_count_q;
  logic [15:0] word_index_q;
  logic [15:0] index_inc;
  logic [15:0] hdr_n;
  logic        accept;
  logic        start_ok;
  logic        asm_last;
  logic        asm_full;
  logic [31:0] asm_word;
  ldr_state_t  after_last;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  assign after_last = LDR_CSUM;
`else
  assign after_last = LDR_DONE;
`endif

  assign in_ready = (state_q == LDR_HDR_HI) || (state_q == LDR_HDR_LO) || (state_q == LDR_DATA)
`ifdef LOADER_CHECKSUM_EN
                    || (state_q == LDR_CSUM)
`endif
                    ;

  assign accept    = in_valid && in_ready;
  assign start_ok  = start && ((state_q == LDR_IDLE) || (state_q == LDR_DONE) || (state_q == LDR_ERROR));
  assign hdr_n     = {word_count_q[15:8], in_data};
  assign index_inc = word_index_q + 16'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= LDR_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LDR_IDLE, LDR_DONE, LDR_ERROR: if (start) state_d = LDR_HDR_HI;
      LDR_HDR_HI: if (accept) state_d = LDR_HDR_LO;
      LDR_HDR_LO: begin
        if (accept) begin
          if (hdr_n == 16'd0)                        state_d = after_last;
          else if (32'(hdr_n) > 32'(INSTR_MEM_SIZE)) state_d = LDR_ERROR;
          else                                       state_d = LDR_DATA;
        end
      end
      LDR_DATA:  if (accept && asm_last) state_d = LDR_WRITE;
      LDR_WRITE: state_d = (index_inc == word_count_q) ? after_last : LDR_DATA;
`ifdef LOADER_CHECKSUM_EN
      LDR_CSUM:  if (accept) state_d = (in_data == csum_q) ? LDR_DONE : LDR_ERROR;
`endif
      default:   state_d = LDR_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_count_q <= 16'd0;
      word_index_q <= 16'd0;
    end else begin
      if (start_ok) begin
        word_count_q <= 16'd0;
        word_index_q <= 16'd0;
      end
      if (state_q == LDR_HDR_HI && accept) word_count_q[15:8] <= in_data;
      if (state_q == LDR_HDR_LO && accept) word_count_q[7:0]  <= in_data;
      if (state_q == LDR_WRITE)            word_index_q       <= index_inc;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                               csum_q <= 8'd0;
    else if (start_ok)                       csum_q <= 8'd0;
    else if (state_q == LDR_DATA && accept)  csum_q <= csum_q ^ in_data;
  end
`endif

  instr_loader_word_assembler u_asm (
    .clock   (clock),
    .reset   (reset),
    .clear   (start_ok || (state_q == LDR_WRITE)),
    .shift   ((state_q == LDR_DATA) && accept),
    .byte_in (in_data),
    .word    (asm_word),
    .last    (asm_last),
    .full    (asm_full)
  );

  // All outputs come from registers or the state register only.
  assign mem_wen   = (state_q == LDR_WRITE) && asm_full;
  assign mem_addr  = word_byte_addr(word_index_q);
  assign mem_din   = asm_word;
  assign done      = (state_q == LDR_DONE);
  assign error     = (state_q == LDR_ERROR);
  assign cpu_reset = (state_q != LDR_DONE);

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - scoreboard bench for instr_loader (checksum cases under LOADER_CHECKSUM_EN)
module tb_instr_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_wen, cpu_reset, done, error;
  logic [31:0] mem_addr, mem_din;

  int checks = 0;
  int errors = 0;
  int wen_count = 0;
  int wen_base;
  logic [63:0] exp_q[$];
  logic [7:0]  img[8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  logic [7:0]  good_csum;

  instr_loader #(.INSTR_MEM_SIZE(1024)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected (addr, data).
  always @(negedge clock) begin
    if (mem_wen) begin
      logic [63:0] e;
      wen_count++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $display("FAIL unexpected_write: observed addr %h data %h expected no write", mem_addr, mem_din);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr", mem_addr, e[63:32]);
        chk("write_data", mem_din, e[31:0]);
      end
    end
  end

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clock);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clock);
    end
    if (!in_ready) chk("byte_accept_timeout", {24'd0, b}, 32'hFFFFFFFF);
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
  endtask

  // Header 00 02 then the first nbytes of the two-word image; expectations pushed per complete word.
  task automatic send_normal(input int gap, input int nbytes);
    send_byte(8'h00, gap);
    send_byte(8'h02, gap);
    for (int k = 0; k < 2; k++)
      if (k * 4 + 4 <= nbytes)
        exp_q.push_back({32'(k * 4), img[k*4], img[k*4+1], img[k*4+2], img[k*4+3]});
    for (int i = 0; i < nbytes; i++) send_byte(img[i], gap);
  endtask

  task automatic wait_end(input logic exp_done);
    int t = 0;
    while (!(done || error) && t < 200) begin
      t++;
      @(negedge clock);
    end
    chk("end_done", done, exp_done);
    chk("end_error", error, !exp_done);
    chk("end_cpu_reset", cpu_reset, !exp_done);
  endtask

  initial begin
    good_csum = 8'h00;
    for (int i = 0; i < 8; i++) good_csum ^= img[i];

    // Reset values
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    @(posedge clock); #1 reset = 1'b0;

    // Normal load
    wen_base = wen_count;
    pulse_start();
    send_normal(0, 8);
`ifdef LOADER_CHECKSUM_EN
    chk("csum_ready", in_ready, 0);
    send_byte(good_csum, 0);
`else
    chk("last_write_wen", mem_wen, 1);
    chk("last_write_ready", in_ready, 0);
    chk("last_write_done", done, 0);
    @(posedge clock); #1;
    chk("done_edge_done", done, 1);
    chk("done_edge_cpu_reset", cpu_reset, 0);
`endif
    wait_end(1'b1);
    chk("normal_pending", exp_q.size(), 0);
    chk("normal_wen_count", wen_count - wen_base, 2);

    // Empty image
    wen_base = wen_count;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    wait_end(1'b1);
    chk("empty_wen_count", wen_count - wen_base, 0);

    // Oversize image, N = 1025
    wen_base = wen_count;
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    wait_end(1'b0);
    repeat (3) @(posedge clock);
    #1;
    chk("oversize_in_ready", in_ready, 0);
    chk("oversize_wen_count", wen_count - wen_base, 0);

    // Throttled stream
    wen_base = wen_count;
    pulse_start();
    send_normal(2, 8);
`ifdef LOADER_CHECKSUM_EN
    send_byte(good_csum, 2);
`endif
    wait_end(1'b1);
    chk("throttle_pending", exp_q.size(), 0);
    chk("throttle_wen_count", wen_count - wen_base, 2);

    // Reset mid-DATA after header + 6 data bytes
    wen_base = wen_count;
    pulse_start();
    send_normal(0, 6);
    #2 reset = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_cpu_reset", cpu_reset, 1);
    chk("midrst_mem_wen", mem_wen, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_din", mem_din, 0);
    @(posedge clock); #1 reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("midrst_pending", exp_q.size(), 0);
    chk("midrst_wen_count", wen_count - wen_base, 1);
    chk("midrst_done", done, 0);

    // Reload after reset
    wen_base = wen_count;
    pulse_start();
    send_normal(0, 8);
`ifdef LOADER_CHECKSUM_EN
    send_byte(good_csum, 0);
`endif
    wait_end(1'b1);
    chk("reload_pending", exp_q.size(), 0);
    chk("reload_wen_count", wen_count - wen_base, 2);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum: words still written, CPU kept in reset
    wen_base = wen_count;
    pulse_start();
    send_normal(0, 8);
    send_byte(good_csum ^ 8'h01, 0);
    wait_end(1'b0);
    chk("badcsum_pending", exp_q.size(), 0);
    chk("badcsum_wen_count", wen_count - wen_base, 2);
`endif

    repeat (5) @(posedge clock);
    #1;
    chk("final_pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader: the writer side of the CPU's instruction-memory read port. It accepts a byte stream over a valid/ready handshake, packs big-endian 32-bit words and writes them into instruction memory at consecutive word addresses from 0. While loading it holds the CPU in reset, and it releases the CPU only after a complete, well-formed image has been written.

## Interface
Parameters:
- INSTR_MEM_SIZE, 1024, instruction memory capacity in 32-bit words; largest accepted image.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte-stream ready; a byte transfers on an edge where in_valid and in_ready are both high.
- mem_wen  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  32  byte address of the word being written, always word-aligned.
- mem_din  out  32  word being written.
- cpu_reset  out  1  high while the CPU must be held in reset.
- done  out  1  image loaded; CPU released.
- error  out  1  image rejected.

## Operation
- Image format: 16-bit word count N, high byte first, followed by N words of 4 bytes each, most significant byte first.
- States are IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE and ERROR.
- IDLE: waits for start.
- start in IDLE, DONE or ERROR moves to HDR_HI and clears done, error and the word index.
- HDR_HI and HDR_LO each accept one byte, forming N.
- After the HDR_LO byte:
  - N == 0 goes to DONE.
  - N > INSTR_MEM_SIZE goes to ERROR.
  - Otherwise the next state is DATA.
- DATA: accepts bytes, shifting each into the low end of a 32-bit assembly register. The 4th accepted byte moves to WRITE.
- WRITE: mem_wen = 1, mem_addr = word_index × 4, mem_din = assembled word. The word index then increments; the next state is DONE if the new index equals N, otherwise DATA.
- DONE: done = 1 and cpu_reset = 0.
- ERROR: error = 1 and cpu_reset = 1. No further memory writes occur until the next start.
- start is ignored in HDR_HI, HDR_LO, DATA and WRITE.
- Word index is 16 bits wide; mem_addr is the index zero-extended and shifted left by 2.

## Timing
- Reset values: in_ready 0, mem_wen 0, mem_addr 0, mem_din 0, cpu_reset 1, done 0, error 0, state IDLE.
- Every output is a registered value or a pure decode of the state register, so there are no combinational paths from inputs to outputs.
- in_ready = 1 exactly in HDR_HI, HDR_LO and DATA. It is 0 in WRITE, so the producer sees backpressure for one cycle per word.
- Minimum rate is 5 cycles per word: 4 byte cycles plus 1 WRITE cycle. in_valid gaps stretch only the byte cycles.
- mem_wen is high exactly in WRITE cycles, with mem_addr and mem_din stable in the same cycle. Memory captures the word on that cycle's closing edge.
- done and cpu_reset change on the edge that enters DONE. For the last word this is the edge closing its WRITE cycle.
- Reset asserted mid-load returns every output to its reset value immediately. A partially assembled word is never written.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - A trailing checksum byte follows the last word; it is the XOR of all 4N data bytes, header excluded.
  - An extra CSUM state accepts the checksum byte with in_ready = 1.
  - A match goes to DONE and a mismatch goes to ERROR. Words already written stay in memory, but cpu_reset remains 1.
  - With N == 0, a checksum byte of 0x00 is expected.
- LOADER_CHECKSUM_EN undefined: there is no CSUM state; the final WRITE goes straight to DONE.

## Structure
- State encodings (LDR_IDLE … LDR_ERROR, plus LDR_CSUM) and the header length constant belong in the shared constants.h.
- One sub-module, word_assembler:
  - 32-bit shift register with a 2-bit byte counter and a full flag; shift, clear and word outputs.
  - Sequenced by the instr_loader FSM.

## Test plan
- Reset check: assert reset mid-cycle. Outputs take their reset values asynchronously, with cpu_reset = 1 and in_ready = 0.
- Normal load: start, then bytes 00 02 12 34 56 78 9A BC DE F0.
  - Writes 0x12345678 @ 0x0 and 0x9ABCDEF0 @ 0x4, each with a one-cycle mem_wen.
  - Then done = 1 and cpu_reset = 0.
- Empty and oversize images:
  - Header 00 00 gives done with no mem_wen.
  - Header 04 01 (N = 1025, default size) gives error = 1, in_ready = 0, no mem_wen and cpu_reset = 1.
- Throttled stream: the normal-load image with in_valid high only every third cycle produces identical writes, and no byte is dropped or duplicated.
- Reset mid-DATA: reset after 6 bytes of the normal-load image (header plus 12 34 56 78 9A BC).
  - No write for the partial second word.
  - A subsequent start with the full image reloads correctly.
- Checksum (LOADER_CHECKSUM_EN defined), after the normal-load image:
  - Trailing byte 0x00 gives done. The correct XOR is 0x12^0x34^0x56^0x78^0x9A^0xBC^0xDE^0xF0 = 0x00.
  - Trailing byte 0x01 gives error = 1 with cpu_reset = 1.
